pwm_frame_loader: RTL

- Upstream feeder for the 16-channel time-multiplexed 64-bit PWM engine.
- Collects per-channel duty-target writes from a control-side valid/ready port into a staging bank.
- On an apply request, arms the staged set and replays it to the engine's update_en/update_idx/target_in inputs over exactly one full channel sweep starting at channel 0, so every channel changes in the same PWM frame.
- Keeps a mirror of the engine's channel scheduler so each update is presented in the cycle the engine services that channel.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_chan_sched.sv | 27 ++
 rtl/pwm_frame_loader.sv | 110 +++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM engine and its frame loader.
// The engine and the loader must agree on channel count and widths.
package pwm_pkg;
   localparam int PWM_NCH   = 16;
   localparam int PWM_IDX_W = 4;
   localparam int PWM_TGT_W = 64;

   typedef logic [PWM_TGT_W-1:0] pwm_target_t;
   typedef logic [PWM_IDX_W-1:0] pwm_idx_t;

   typedef enum logic [1:0] {IDLE, ARMED, SWEEP} loader_state_e;
endpackage

// File: rtl/pwm_chan_sched.sv
// Channel scheduler: en-gated index counter wrapping NCH-1 -> 0.
// Shared with the engine so both sides always point at the same channel.
module pwm_chan_sched
   import pwm_pkg::*;
#(
   parameter int NCH   = PWM_NCH,
   parameter int IDX_W = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   output logic [IDX_W-1:0] idx_o
);
   logic [IDX_W-1:0] idx_q, idx_d;

   always_comb begin
      idx_d = idx_q;
      if (en_i) idx_d = (idx_q == IDX_W'(NCH-1)) ? '0 : idx_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idx_q <= '0;
      else        idx_q <= idx_d;
   end

   assign idx_o = idx_q;
endmodule

// File: rtl/pwm_frame_loader.sv
// Stages per-channel PWM targets and replays them to the engine across one
// full channel sweep starting at channel 0, so all updates land in one frame.
module pwm_frame_loader
   import pwm_pkg::*;
#(
   parameter int NCH   = PWM_NCH,
   parameter int IDX_W = $clog2(NCH),
   parameter int TGT_W = PWM_TGT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [IDX_W-1:0] req_ch,
   input  logic [TGT_W-1:0] req_target,
   output logic             req_overwrite,
   input  logic             apply_valid,
   output logic             apply_ready,
   output logic             apply_done,
   output logic             upd_en,
   output logic [IDX_W-1:0] upd_idx,
   output logic [TGT_W-1:0] upd_target
);
   loader_state_e    state_q, state_d;
   logic [IDX_W-1:0] idx;
   logic             rdy_q, ov_q, done_q;
   logic [NCH-1:0]   stg_vld_q, stg_vld_d, arm_vld_q, arm_vld_d;
   logic [TGT_W-1:0] stg_tgt_q [NCH];
   logic [TGT_W-1:0] arm_tgt_q [NCH];
   logic             req_take, apply_take, stg_any, arm_go, sweep_end, active;

   pwm_chan_sched #(.NCH(NCH), .IDX_W(IDX_W)) u_sched (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (en),
      .idx_o (idx)
   );

   assign req_take   = req_valid && rdy_q;
   assign apply_take = apply_valid && apply_ready;
   assign stg_any    = |stg_vld_q;
   assign arm_go     = apply_take && stg_any;
   assign sweep_end  = (state_q == SWEEP) && en && (idx == IDX_W'(NCH-1));

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (arm_go) state_d = ARMED;
         ARMED:   if (en && idx == '0) state_d = SWEEP;
         SWEEP:   if (sweep_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs, purely from registers so the engine sees them with zero latency
   always_comb begin
      apply_ready = rdy_q && (state_q == IDLE);
      active      = ((state_q == ARMED) && idx == '0) || (state_q == SWEEP);
      upd_en      = active && arm_vld_q[idx];
      upd_idx     = idx;
      upd_target  = upd_en ? arm_tgt_q[idx] : '0;
   end

   // A write in the same cycle as an accepted apply lands in the freshly cleared bank
   always_comb begin
      stg_vld_d = stg_vld_q;
      if (arm_go)   stg_vld_d = '0;
      if (req_take) stg_vld_d[req_ch] = 1'b1;
   end

   always_comb begin
      arm_vld_d = arm_vld_q;
      if (sweep_end) arm_vld_d = '0;
      if (arm_go)    arm_vld_d = stg_vld_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q     <= 1'b0;
         ov_q      <= 1'b0;
         done_q    <= 1'b0;
         stg_vld_q <= '0;
         arm_vld_q <= '0;
      end else begin
         rdy_q     <= 1'b1;
         ov_q      <= req_take && stg_vld_q[req_ch] && !arm_go;
         done_q    <= (apply_take && !stg_any) || sweep_end;
         stg_vld_q <= stg_vld_d;
         arm_vld_q <= arm_vld_d;
      end
   end

   // Target data is qualified by the valid bits, so it carries no reset
   always_ff @(posedge clk) begin
      if (req_take) stg_tgt_q[req_ch] <= req_target;
      if (arm_go)   arm_tgt_q <= stg_tgt_q;
   end

   assign req_ready     = rdy_q;
   assign req_overwrite = ov_q;
   assign apply_done    = done_q;
endmodule
